tick_gen_bank: RTL
==================

// Module: tick_gen_bank
// PURPOSE
//   Parametrised bank of NUM_CH independent clock-enable generators. Each channel has a runtime-loadable
//   divisor and a modulo step (beat) counter. One-cycle tick/wrap pulses drive game timing, note scroll,
//   and video-sequencing logic. All channels run from the single CLK.
// PARAMETERS
//   NUM_CH        4         number of channels (>=1)
//   DIV_W         26        divisor/prescaler width
//   STEP_W        8         step counter width
//   DEF_DIV       12499999  reset divisor, all channels (4 Hz at 50 MHz)
//   DEF_STEP_MAX  160       reset step wrap limit, all channels
// PORTS
//   CLK       in   1                  system clock; all logic on posedge
//   reset     in   1                  asynchronous, active-high; clears all state
//   run       in   NUM_CH             per-channel run enable (level)
//   sync_clr  in   1                  synchronous clear of all prescalers and step counters
//   wr_en     in   1                  config write strobe
//   wr_ch     in   CH_W               target channel; CH_W = max(1,$clog2(NUM_CH))
//   wr_sel    in   1                  0 = divisor, 1 = step_max
//   wr_data   in   DIV_W              write data; step_max takes wr_data[STEP_W-1:0]
//   tick      out  NUM_CH             one-cycle enable pulse per channel
//   wrap      out  NUM_CH             one-cycle pulse when the step counter wraps
//   step      out  NUM_CH*STEP_W      step counters; channel i at [i*STEP_W +: STEP_W]
// BEHAVIOUR
//   - Reset: presc=0, step=0, tick=0, wrap=0. div_act=div_shd=DEF_DIV. smax_act=smax_shd=DEF_STEP_MAX.
//   - Prescaler, run=1: if presc==div_act then presc<=0 and tick<=1 (registered, next cycle).
//     Otherwise presc<=presc+1 and tick<=0. Tick period = div_act+1 cycles. div_act=0 -> tick every cycle.
//   - run=0: presc, step and tick/wrap outputs hold; tick=0 and wrap=0 while stopped. Resuming continues
//     from the held count.
//   - Step counter advances on the internal terminal condition, in the same cycle tick is registered:
//     if step==smax_act then step<=0 and wrap<=1, else step<=step+1. step and tick update together.
//   - Config write: wr_en loads the shadow register (div_shd or smax_shd) of channel wr_ch.
//     The shadow is copied to the active register at the next prescaler terminal count, or immediately
//     if run=0, so the current period is never truncated.
//     wr_ch >= NUM_CH: write ignored.
//   - Live limit below count: if smax_act is lowered below the current step, step keeps counting up to
//     2^STEP_W-1, wraps to 0 with no wrap pulse, then obeys the new limit. presc cannot exceed div_act
//     because loads occur only at terminal count or while stopped.
//   - sync_clr: presc=0 and step=0 for all channels, no tick/wrap that cycle. Shadows are preserved and
//     loaded to active. sync_clr has priority over a coincident terminal count and over run.
//   - Simultaneous wr_en and terminal count on the same channel: the new value is written to the shadow
//     and also taken as active at that boundary (write-through).
//   - Reset asserted mid-operation: immediate clear, no glitch pulses; first tick is DEF_DIV+1 cycles
//     after reset deassert with run=1.
//   - Arithmetic is unsigned and modulo-width; no saturation.
// STRUCTURE
//   - tick_gen_pkg: CH_W function and default-constant localparams (DEF_DIV_4HZ=12499999,
//     DEF_DIV_64HZ=781249, DEF_STEP_MAX=160), shared with the game FSM.
//   - Sub-module tick_gen_channel: one prescaler, step counter, and shadow/active pair.
//     Instantiated NUM_CH times by generate. The top decodes wr_ch and packs the step bus.
// TESTING
//   1. Reset, run=1, ch0 div=3 -> tick[0] every 4 cycles; step[0] 0,1,2..; first tick 4 cycles after release.
//   2. ch1 div=0, smax=2 -> tick every cycle; step 0,1,2,0; wrap pulses on the 2->0 cycle only.
//   3. ch0 running div=9, write div=4 mid-period -> current period completes at 10, then period 5.
//   4. sync_clr on the same cycle as a ch2 terminal count -> no tick, presc=step=0, next tick div+1 later.
//   5. run toggled 0 for 7 cycles mid-count -> tick delayed by exactly 7 cycles; write with run=0 applies immediately.
//   6. Async reset mid-period with wr_ch=NUM_CH write pending -> all outputs 0 in the same cycle; defaults restored.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: constants and helpers shared by the tick generator bank
// and the game FSM.
//   ch_w()        width of a channel index (at least 1 bit)
//   wr_sel_e      selects which shadow register a config write targets
//   DEF_DIV_*     prescaler divisors for common rates at a 50 MHz clock
package tick_gen_pkg;
  localparam int DEF_DIV_4HZ  = 12499999;
  localparam int DEF_DIV_64HZ = 781249;
  localparam int DEF_STEP_MAX = 160;

  typedef enum logic {
    SEL_DIV  = 1'b0,
    SEL_SMAX = 1'b1
  } wr_sel_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_gen_bank_if.sv
// tick_gen_bank_if: control/config and output bundle of the tick bank.
//   run       per-channel run enable (level)
//   sync_clr  clear all prescalers and step counters
//   wr_en/wr_ch/wr_sel/wr_data  config write into a channel shadow register
//   tick/wrap one-cycle pulses per channel
//   step      step counters, channel i at [i*STEP_W +: STEP_W]
// master drives control and reads outputs; slave is the bank.
interface tick_gen_bank_if import tick_gen_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 26,
  parameter int STEP_W = 8
);
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]        run;
  logic                     sync_clr;
  logic                     wr_en;
  logic [CH_W-1:0]          wr_ch;
  logic                     wr_sel;
  logic [DIV_W-1:0]         wr_data;
  logic [NUM_CH-1:0]        tick;
  logic [NUM_CH-1:0]        wrap;
  logic [NUM_CH*STEP_W-1:0] step;

  modport master (output run, sync_clr, wr_en, wr_ch, wr_sel, wr_data,
                  input  tick, wrap, step);
  modport slave  (input  run, sync_clr, wr_en, wr_ch, wr_sel, wr_data,
                  output tick, wrap, step);
endinterface

// File: rtl/tick_gen_channel.sv
// tick_gen_channel: one prescaler + modulo step counter with shadow/active
// divisor and step limit.
//   clk_i, rst_i   clock, async active-high reset
//   run_i          count enable; outputs hold while low
//   clr_i          synchronous clear of prescaler and step counter
//   wr_i           write strobe for this channel, wr_sel_i picks target
//   wr_data_i      write data (step limit uses the low STEP_W bits)
//   tick_o/wrap_o  registered one-cycle pulses
//   step_o         current step count
module tick_gen_channel import tick_gen_pkg::*; #(
  parameter int DIV_W    = 26,
  parameter int STEP_W   = 8,
  parameter int DEF_DIV  = DEF_DIV_4HZ,
  parameter int DEF_SMAX = DEF_STEP_MAX
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic              wr_sel_i,
  input  logic [DIV_W-1:0]  wr_data_i,
  output logic              tick_o,
  output logic              wrap_o,
  output logic [STEP_W-1:0] step_o
);
  logic [DIV_W-1:0]  presc_q, div_act_q, div_shd_q, div_shd_d;
  logic [STEP_W-1:0] step_q, smax_act_q, smax_shd_q, smax_shd_d;
  logic              tick_q, wrap_q;
  logic              term, load;

  // Shadow next-state; also the value taken as active on a load, so a write
  // landing on a terminal count goes straight through.
  always_comb begin
    div_shd_d  = div_shd_q;
    smax_shd_d = smax_shd_q;
    if (wr_i) begin
      if (wr_sel_e'(wr_sel_i) == SEL_SMAX) smax_shd_d = wr_data_i[STEP_W-1:0];
      else                                 div_shd_d  = wr_data_i;
    end
  end

  assign term = (presc_q == div_act_q);
  // Active limits change only between periods: at terminal count, while
  // stopped, or on a clear, so a running period is never cut short.
  assign load = clr_i || !run_i || term;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q    <= '0;
      step_q     <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      div_act_q  <= DIV_W'(DEF_DIV);
      div_shd_q  <= DIV_W'(DEF_DIV);
      smax_act_q <= STEP_W'(DEF_SMAX);
      smax_shd_q <= STEP_W'(DEF_SMAX);
    end else begin
      div_shd_q  <= div_shd_d;
      smax_shd_q <= smax_shd_d;
      if (load) begin
        div_act_q  <= div_shd_d;
        smax_act_q <= smax_shd_d;
      end
      if (clr_i) begin
        presc_q <= '0;
        step_q  <= '0;
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end else if (!run_i) begin
        tick_q <= 1'b0;
        wrap_q <= 1'b0;
      end else if (term) begin
        presc_q <= '0;
        tick_q  <= 1'b1;
        // A limit lowered below the count never matches; the counter rolls
        // over naturally without a wrap pulse.
        if (step_q == smax_act_q) begin
          step_q <= '0;
          wrap_q <= 1'b1;
        end else begin
          step_q <= step_q + 1'b1;
          wrap_q <= 1'b0;
        end
      end else begin
        presc_q <= presc_q + 1'b1;
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end
    end
  end

  assign tick_o = tick_q;
  assign wrap_o = wrap_q;
  assign step_o = step_q;
endmodule

// File: rtl/tick_gen_bank.sv
// tick_gen_bank: NUM_CH independent clock-enable generators on one clock.
//   CLK    system clock
//   reset  async active-high reset
//   bus    control, config write and tick/wrap/step outputs (slave side)
// Decodes the config write channel and packs per-channel step counters.
module tick_gen_bank #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 26,
  parameter int STEP_W       = 8,
  parameter int DEF_DIV      = tick_gen_pkg::DEF_DIV_4HZ,
  parameter int DEF_STEP_MAX = tick_gen_pkg::DEF_STEP_MAX
) (
  input logic             CLK,
  input logic             reset,
  tick_gen_bank_if.slave  bus
);
  import tick_gen_pkg::*;
  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0][STEP_W-1:0] step_q;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic wr_hit;
      // Channel indices >= NUM_CH match nothing, so such writes drop.
      assign wr_hit = bus.wr_en && (bus.wr_ch == CH_W'(g));

      tick_gen_channel #(
        .DIV_W   (DIV_W),
        .STEP_W  (STEP_W),
        .DEF_DIV (DEF_DIV),
        .DEF_SMAX(DEF_STEP_MAX)
      ) u_ch (
        .clk_i    (CLK),
        .rst_i    (reset),
        .run_i    (bus.run[g]),
        .clr_i    (bus.sync_clr),
        .wr_i     (wr_hit),
        .wr_sel_i (bus.wr_sel),
        .wr_data_i(bus.wr_data),
        .tick_o   (bus.tick[g]),
        .wrap_o   (bus.wrap[g]),
        .step_o   (step_q[g])
      );
    end
  endgenerate

  assign bus.step = step_q;
endmodule
